// File: rtl/median_window_gen_5x5.sv
// median_window_gen_5x5: buffers four image lines and presents a 5x5 raster window with a valid flag
// Build option: define SOF_RESYNC_EN to add the in_sof frame-resync input.
// pix1..pix5 hold the oldest row (r-4) and pix21..pix25 the current row (r).
// Within each row the lowest index is the leftmost column.
module median_window_gen_5x5 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
`ifdef SOF_RESYNC_EN
    input  logic          in_sof,
`endif
    input  logic [DW-1:0] in_pix,
    output logic          out_valid,
    output logic [DW-1:0] pix1,  pix2,  pix3,  pix4,  pix5,
    output logic [DW-1:0] pix6,  pix7,  pix8,  pix9,  pix10,
    output logic [DW-1:0] pix11, pix12, pix13, pix14, pix15,
    output logic [DW-1:0] pix16, pix17, pix18, pix19, pix20,
    output logic [DW-1:0] pix21, pix22, pix23, pix24, pix25,
    output logic [15:0]   out_row,
    output logic [15:0]   out_col
);
    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);

    logic [15:0]   col_cnt, row_cnt, eff_col, eff_row, col_nxt, row_nxt;
    logic          sof, acc, col_wrap, win_ok;
    logic [AW-1:0] addr;
    logic [DW-1:0] lb [4][IMG_WIDTH];
    logic [DW-1:0] rd [4];
    logic [DW-1:0] win [25];

`ifdef SOF_RESYNC_EN
    assign sof = in_sof;
`else
    assign sof = 1'b0;
`endif

    // An sof pixel is treated as (0,0); it addresses the RAMs and seeds the counters from there
    always_comb begin
        acc      = in_valid && !rst;
        eff_col  = sof ? 16'd0 : col_cnt;
        eff_row  = sof ? 16'd0 : row_cnt;
        addr     = eff_col[AW-1:0];
        col_wrap = eff_col == COL_LAST;
        col_nxt  = col_wrap ? 16'd0 : eff_col + 16'd1;
        row_nxt  = col_wrap ? ((eff_row == ROW_LAST) ? 16'd0 : eff_row + 16'd1) : eff_row;
        win_ok   = eff_row >= 16'd4 && eff_col >= 16'd4;
        for (int k = 0; k < 4; k++) rd[k] = lb[k][addr];
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (acc) begin
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
        end
    end

    // Line buffers cascade one line older per accept; reads above happen before these writes
    always_ff @(posedge clk) begin
        if (acc) begin
            lb[0][addr] <= in_pix;
            lb[1][addr] <= rd[0];
            lb[2][addr] <= rd[1];
            lb[3][addr] <= rd[2];
        end
    end

    // Window shifts left one column per accept; the new right column comes from the buffers and in_pix
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            for (int k = 0; k < 25; k++) win[k] <= '0;
        end else begin
            out_valid <= acc && win_ok;
            if (acc) begin
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 4; j++)
                        win[i*5+j] <= win[i*5+j+1];
                win[4]  <= rd[3];
                win[9]  <= rd[2];
                win[14] <= rd[1];
                win[19] <= rd[0];
                win[24] <= in_pix;
                out_row <= eff_row;
                out_col <= eff_col;
            end
        end
    end

    assign pix1  = win[0];  assign pix2  = win[1];  assign pix3  = win[2];  assign pix4  = win[3];  assign pix5  = win[4];
    assign pix6  = win[5];  assign pix7  = win[6];  assign pix8  = win[7];  assign pix9  = win[8];  assign pix10 = win[9];
    assign pix11 = win[10]; assign pix12 = win[11]; assign pix13 = win[12]; assign pix14 = win[13]; assign pix15 = win[14];
    assign pix16 = win[15]; assign pix17 = win[16]; assign pix18 = win[17]; assign pix19 = win[18]; assign pix20 = win[19];
    assign pix21 = win[20]; assign pix22 = win[21]; assign pix23 = win[22]; assign pix24 = win[23]; assign pix25 = win[24];
endmodule

// File: tb/tb_median_window_gen_5x5.sv
// tb_median_window_gen_5x5: scoreboard bench for the 5x5 window generator on an 8x6 ramp image
module tb_median_window_gen_5x5;
    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        logic [15:0]  r;
        logic [15:0]  c;
        logic [199:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [7:0]  in_pix = '0;
    logic        out_valid;
    logic [7:0]  pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9, pix10;
    logic [7:0]  pix11, pix12, pix13, pix14, pix15, pix16, pix17, pix18, pix19, pix20;
    logic [7:0]  pix21, pix22, pix23, pix24, pix25;
    logic [15:0] out_row, out_col;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_valid = 0;
    int          r = 0;
    int          c = 0;
    int          drv_r = 0;
    int          drv_c = 0;
    logic        chk_en = 1'b0;
    logic        exp_v = 1'b0;
    logic [15:0] exp_r = '0;
    logic [15:0] exp_c = '0;
    exp_t        q[$];

    median_window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef SOF_RESYNC_EN
        .in_sof(in_sof),
`endif
        .in_pix(in_pix), .out_valid(out_valid),
        .pix1(pix1), .pix2(pix2), .pix3(pix3), .pix4(pix4), .pix5(pix5),
        .pix6(pix6), .pix7(pix7), .pix8(pix8), .pix9(pix9), .pix10(pix10),
        .pix11(pix11), .pix12(pix12), .pix13(pix13), .pix14(pix14), .pix15(pix15),
        .pix16(pix16), .pix17(pix17), .pix18(pix18), .pix19(pix19), .pix20(pix20),
        .pix21(pix21), .pix22(pix22), .pix23(pix23), .pix24(pix24), .pix25(pix25),
        .out_row(out_row), .out_col(out_col)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Pixel value at image position (row, col) is row*16+col
    function automatic logic [199:0] mkwin(input int wr, input int wc);
        logic [199:0] w;
        w = '0;
        for (int k = 0; k < 25; k++) w[k*8 +: 8] = 8'((wr - 4 + k / 5) * 16 + (wc - 4 + k % 5));
        return w;
    endfunction

    // Reference position/valid tracker: what the DUT should show after each edge
    always @(posedge clk) begin
        if (rst) begin
            exp_v <= 1'b0;
            exp_r <= '0;
            exp_c <= '0;
        end else if (in_valid) begin
            exp_v <= drv_r >= 4 && drv_c >= 4;
            exp_r <= 16'(drv_r);
            exp_c <= 16'(drv_c);
        end else begin
            exp_v <= 1'b0;
        end
    end

    // Monitor: every cycle checks valid/position, pops the scoreboard on each valid window
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            chk("out_row", 32'(out_row), 32'(exp_r));
            chk("out_col", 32'(out_col), 32'(exp_c));
            if (out_valid) begin
                n_valid++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_window: got valid at (%0d,%0d) required none", out_row, out_col);
                end else begin
                    logic [199:0] dw;
                    e = q.pop_front();
                    dw = {pix25, pix24, pix23, pix22, pix21, pix20, pix19, pix18, pix17, pix16,
                          pix15, pix14, pix13, pix12, pix11, pix10, pix9, pix8, pix7, pix6,
                          pix5, pix4, pix3, pix2, pix1};
                    chk("win_row", 32'(out_row), 32'(e.r));
                    chk("win_col", 32'(out_col), 32'(e.c));
                    n_vec++;
                    if (dw !== e.w) begin
                        n_err++;
                        $display("FAIL window(%0d,%0d): got %h required %h", e.r, e.c, dw, e.w);
                    end
                    if (e.r == 4 && e.c == 4) begin
                        chk("first_pix1", 32'(pix1), 32'h00);
                        chk("first_pix13", 32'(pix13), 32'h22);
                        chk("first_pix25", 32'(pix25), 32'h44);
                    end
                    if (e.r == 5 && e.c == 4) begin
                        chk("wrap_pix1", 32'(pix1), 32'h10);
                        chk("wrap_pix25", 32'(pix25), 32'h54);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic s);
        if (v && s) begin
            r = 0;
            c = 0;
        end
        in_valid = v;
        in_sof = s;
        in_pix = 8'(r * 16 + c);
        drv_r = r;
        drv_c = c;
        if (v && r >= 4 && c >= 4) q.push_back('{16'(r), 16'(c), mkwin(r, c)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        if (v) begin
            c++;
            if (c == W) begin
                c = 0;
                r++;
                if (r == H) r = 0;
            end
        end
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
    endtask

    task automatic expect_count(input string nm, input int base, input int want);
        repeat (3) @(posedge clk);
        #1;
        chk(nm, 32'(n_valid - base), 32'(want));
    endtask

    initial begin
        int base;
        int acc;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_pix1", 32'(pix1), 32'h0);
        chk("rst_pix25", 32'(pix25), 32'h0);
        chk("rst_row", 32'(out_row), 32'h0);
        #1;

        base = n_valid;
        send(W * H);
        expect_count("frame_count", base, 8);

        base = n_valid;
        acc = 0;
        for (int i = 0; i < 2000 && acc < W * H; i++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            drive(v, 1'b0);
            if (v) acc++;
        end
        expect_count("bubble_count", base, 8);

        send(20);
        in_valid = 1'b1;
        in_pix = 8'h99;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        r = 0;
        c = 0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_row", 32'(out_row), 32'h0);
        #1;
        base = n_valid;
        send(W * H);
        expect_count("after_rst_count", base, 8);

        base = n_valid;
        send(2 * W * H);
        expect_count("two_frame_count", base, 16);

`ifdef SOF_RESYNC_EN
        send(9);
        base = n_valid;
        drive(1'b1, 1'b1);
        send(W * H - 1);
        expect_count("sof_count", base, 8);
        drive(1'b0, 1'b1);
        send(W * H);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
